// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the serial binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2d_state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the digit is 5 or more
//
// Ports:
//   digit_in   BCD digit before the shift
//   digit_out  corrected digit, ready to be shifted left by one
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // 4-bit wrap is harmless: a valid BCD digit never exceeds 9, so 9+3=12 fits.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - sequential sign/magnitude to packed BCD converter (shift-add-3)
//
// Optional feature macro: BIN2BCD_DIGCNT_EN adds the out_ndig significant-digit count.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid/in_ready     input handshake; ready only while idle
//   in_sign, in_mag       sign flag and unsigned magnitude to convert
//   out_valid/out_ready   output handshake; result held until accepted
//   out_sign              negative flag, never set for a zero magnitude
//   out_bcd               packed digits, digit k at [4k+3:4k], digit 0 = units
//   out_ndig              index of the highest nonzero digit + 1, minimum 1
module bin2bcd_serial
    import bcd_pkg::*;
#(
    parameter int DATA_W = 25,
    parameter int DIGITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [DATA_W-1:0]            in_mag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sign,
`ifdef BIN2BCD_DIGCNT_EN
    output logic [$clog2(DIGITS+1)-1:0]  out_ndig,
`endif
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int NDIG_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // The digit field must hold the largest magnitude; otherwise the top digit
    // would silently wrap since digits do not carry into one another.
    if (pow10(DIGITS) <= ((64'd1 << DATA_W) - 64'd1)) begin : g_bad_params
        $error("bin2bcd_serial: DIGITS too small for DATA_W");
    end

    b2d_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic [BCD_W-1:0]  out_bcd_q, out_bcd_d;
    logic              out_sign_q, out_sign_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic [DATA_W-1:0] mag_shift;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_add3 u_add3 (
            .digit_in  (bcd_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // One double-dabble step: the magnitude MSB enters the units digit.
    always_comb begin
        {bcd_shift, mag_shift} = {bcd_adj, mag_q} << 1;
    end

`ifdef BIN2BCD_DIGCNT_EN
    logic [NDIG_W-1:0] out_ndig_q, out_ndig_d;

    function automatic logic [NDIG_W-1:0] count_digits(input logic [BCD_W-1:0] bcd);
        logic [NDIG_W-1:0] n;
        n = NDIG_W'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W] != '0) begin
                n = NDIG_W'(k + 1);
            end
        end
        return n;
    endfunction

    assign out_ndig = out_ndig_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        sign_d     = sign_q;
        out_bcd_d  = out_bcd_q;
        out_sign_d = out_sign_q;
`ifdef BIN2BCD_DIGCNT_EN
        out_ndig_d = out_ndig_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    mag_d   = in_mag;
                    bcd_d   = '0;
                    // Folding the zero test in here rules out a negative zero.
                    sign_d  = in_sign & (in_mag != '0);
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                mag_d = mag_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    out_bcd_d  = bcd_shift;
                    out_sign_d = sign_q;
`ifdef BIN2BCD_DIGCNT_EN
                    out_ndig_d = count_digits(bcd_shift);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            sign_q     <= 1'b0;
            out_bcd_q  <= '0;
            out_sign_q <= 1'b0;
`ifdef BIN2BCD_DIGCNT_EN
            out_ndig_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            sign_q     <= sign_d;
            out_bcd_q  <= out_bcd_d;
            out_sign_q <= out_sign_d;
`ifdef BIN2BCD_DIGCNT_EN
            out_ndig_q <= out_ndig_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = out_bcd_q;
    assign out_sign  = out_sign_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb/tb_bin2bcd_serial.sv - directed self-checking bench for bin2bcd_serial
module tb_bin2bcd_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [24:0] in_mag;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [31:0] out_bcd;
`ifdef BIN2BCD_DIGCNT_EN
    logic [3:0]  out_ndig;
`endif

    int checks   = 0;
    int failures = 0;

    bin2bcd_serial #(.DATA_W(25), .DIGITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mag    (in_mag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
`ifdef BIN2BCD_DIGCNT_EN
        .out_ndig  (out_ndig),
`endif
        .out_bcd   (out_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one value in IDLE; returns #1 after the accept edge.
    task automatic drive_accept(input logic [24:0] mag, input logic sign);
        @(negedge clk);
        in_valid = 1'b1;
        in_mag   = mag;
        in_sign  = sign;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, with a cycle budget.
    task automatic wait_out(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_bcd !== 32'h0 || out_sign !== 1'b0) begin failures++; $display("FAIL reset_out got=%h/%b exp=0/0", out_bcd, out_sign); end
`ifdef BIN2BCD_DIGCNT_EN
        checks++; if (out_ndig !== 4'd0) begin failures++; $display("FAIL reset_ndig got=%0d exp=0", out_ndig); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int n;
        drive_accept(25'd0, 1'b1);
        wait_out(n);
        checks++; if (n !== 25) begin failures++; $display("FAIL zero_latency got=%0d exp=25", n); end
        checks++; if (out_bcd !== 32'h0) begin failures++; $display("FAIL zero_bcd got=%h exp=00000000", out_bcd); end
        checks++; if (out_sign !== 1'b0) begin failures++; $display("FAIL zero_sign got=%b exp=0", out_sign); end
`ifdef BIN2BCD_DIGCNT_EN
        checks++; if (out_ndig !== 4'd1) begin failures++; $display("FAIL zero_ndig got=%0d exp=1", out_ndig); end
`endif
        release_out();
    endtask

    task automatic test_max();
        int n;
        drive_accept(25'd33554431, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL max_busy_ready got=%b exp=0", in_ready); end
        wait_out(n);
        checks++; if (n !== 25) begin failures++; $display("FAIL max_latency got=%0d exp=25", n); end
        checks++; if (out_bcd !== 32'h33554431) begin failures++; $display("FAIL max_bcd got=%h exp=33554431", out_bcd); end
        checks++; if (out_sign !== 1'b0) begin failures++; $display("FAIL max_sign got=%b exp=0", out_sign); end
`ifdef BIN2BCD_DIGCNT_EN
        checks++; if (out_ndig !== 4'd8) begin failures++; $display("FAIL max_ndig got=%0d exp=8", out_ndig); end
`endif
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL max_release got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_negative();
        int n;
        drive_accept(25'd12345, 1'b1);
        wait_out(n);
        checks++; if (out_bcd !== 32'h00012345) begin failures++; $display("FAIL neg_bcd got=%h exp=00012345", out_bcd); end
        checks++; if (out_sign !== 1'b1) begin failures++; $display("FAIL neg_sign got=%b exp=1", out_sign); end
`ifdef BIN2BCD_DIGCNT_EN
        checks++; if (out_ndig !== 4'd5) begin failures++; $display("FAIL neg_ndig got=%0d exp=5", out_ndig); end
`endif
        release_out();
    endtask

    task automatic test_backpressure();
        int n;
        drive_accept(25'd4096, 1'b1);
        wait_out(n);
        in_valid = 1'b1;
        in_mag   = 25'd999;
        in_sign  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 32'h00004096 || out_sign !== 1'b1) begin
                failures++;
                $display("FAIL hold_%0d got v=%b r=%b bcd=%h s=%b exp v=1 r=0 bcd=00004096 s=1",
                         i, out_valid, in_ready, out_bcd, out_sign);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%b/%b exp=0/1", out_valid, in_ready); end
        checks++; if (out_bcd !== 32'h00004096) begin failures++; $display("FAIL hold_after_release got=%h exp=00004096", out_bcd); end
    endtask

    task automatic test_ignore_in_valid();
        int n;
        drive_accept(25'd500, 1'b0);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                in_valid = 1'b1;
                in_mag   = 25'd999;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) break;
        end
        in_valid = 1'b0;
        checks++; if (n !== 25) begin failures++; $display("FAIL ignore_latency got=%0d exp=25", n); end
        checks++; if (out_bcd !== 32'h00000500) begin failures++; $display("FAIL ignore_bcd got=%h exp=00000500", out_bcd); end
        release_out();
        // Nothing was queued by the stray pulse: the converter must stay idle.
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ignore_idle got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        drive_accept(25'd90, 1'b0);
        wait_out(n);
        release_out();
        drive_accept(25'd1000000, 1'b0);
        wait_out(n);
        checks++; if (n !== 25) begin failures++; $display("FAIL b2b_latency got=%0d exp=25", n); end
        checks++; if (out_bcd !== 32'h01000000) begin failures++; $display("FAIL b2b_bcd got=%h exp=01000000", out_bcd); end
`ifdef BIN2BCD_DIGCNT_EN
        checks++; if (out_ndig !== 4'd7) begin failures++; $display("FAIL b2b_ndig got=%0d exp=7", out_ndig); end
`endif
        release_out();
    endtask

    task automatic test_reset_mid();
        int n;
        drive_accept(25'd6, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midrst_handshake got=%b/%b exp=0/1", out_valid, in_ready); end
        checks++; if (out_bcd !== 32'h0 || out_sign !== 1'b0) begin failures++; $display("FAIL midrst_out got=%h/%b exp=0/0", out_bcd, out_sign); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_accept(25'd7, 1'b0);
        wait_out(n);
        checks++; if (n !== 25) begin failures++; $display("FAIL midrst_latency got=%0d exp=25", n); end
        checks++; if (out_bcd !== 32'h00000007 || out_sign !== 1'b0) begin failures++; $display("FAIL midrst_next got=%h/%b exp=00000007/0", out_bcd, out_sign); end
`ifdef BIN2BCD_DIGCNT_EN
        checks++; if (out_ndig !== 4'd1) begin failures++; $display("FAIL midrst_ndig got=%0d exp=1", out_ndig); end
`endif
        release_out();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_negative();
        test_backpressure();
        test_ignore_in_valid();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
